// File: rtl/sm4_word_driver.sv
// SM4 word driver: packs a word stream into 128-bit blocks, issues them to the
// engine with key and mode, then drains the result back out as words.
// Ports:
//   clk_i, reset_i                  : clock, synchronous active-high reset
//   word_i/word_v_i/word_ready_o    : input word stream (valid/ready)
//   key_i, mode_i                   : block key and mode, taken with word 0
//   content_o/key_o/encode_or_decode_o/v_o/ready_i : engine request
//   crypt_i/crypt_v_i/yumi_o        : engine result, yumi_o consumes it
//   out_word_o/out_v_o/out_ready_i  : output word stream (valid/ready)
//   blocks_done_o                   : completed block counter (wraps)
module sm4_word_driver #(
    parameter int word_width_p = 32
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [word_width_p-1:0] word_i,
    input  logic                    word_v_i,
    output logic                    word_ready_o,
    input  logic [127:0]            key_i,
    input  logic                    mode_i,
    output logic [127:0]            content_o,
    output logic [127:0]            key_o,
    output logic                    encode_or_decode_o,
    output logic                    v_o,
    input  logic                    ready_i,
    input  logic [127:0]            crypt_i,
    input  logic                    crypt_v_i,
    output logic                    yumi_o,
    output logic [word_width_p-1:0] out_word_o,
    output logic                    out_v_o,
    input  logic                    out_ready_i,
    output logic [15:0]             blocks_done_o
);

    localparam int group_size_p = 128;
    localparam int words_lp     = group_size_p / word_width_p;
    localparam int idx_w_lp     = (words_lp > 1) ? $clog2(words_lp) : 1;
    localparam logic [idx_w_lp-1:0] last_idx_lp = idx_w_lp'(words_lp - 1);

    typedef enum logic [1:0] {eFill, eIssue, eWait, eDrain} state_e;

    state_e                  state_r;
    logic [idx_w_lp-1:0]     fill_idx_r;
    logic [idx_w_lp-1:0]     drain_idx_r;
    logic [group_size_p-1:0] content_r;
    logic [group_size_p-1:0] key_r;
    logic [group_size_p-1:0] result_r;
    logic                    mode_r;
    logic [15:0]             blocks_done_r;

    logic word_xfer;
    logic req_xfer;
    logic out_xfer;

    // Handshake strobes are gated by reset so nothing is offered while held.
    assign word_ready_o = ~reset_i & (state_r == eFill);
    assign v_o          = ~reset_i & (state_r == eIssue);
    assign yumi_o       = ~reset_i & (state_r == eWait) & crypt_v_i;
    assign out_v_o      = ~reset_i & (state_r == eDrain);

    assign word_xfer = word_v_i & word_ready_o;
    assign req_xfer  = v_o & ready_i;
    assign out_xfer  = out_v_o & out_ready_i;

    assign content_o          = content_r;
    assign key_o              = key_r;
    assign encode_or_decode_o = mode_r;
    assign blocks_done_o      = blocks_done_r;

    // Result is sliced MSB-first; result_r is cleared on reset, so the
    // output word reads as zero after reset.
    assign out_word_o = result_r[group_size_p-1-int'(drain_idx_r)*word_width_p -: word_width_p];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r       <= eFill;
            fill_idx_r    <= '0;
            drain_idx_r   <= '0;
            content_r     <= '0;
            key_r         <= '0;
            result_r      <= '0;
            mode_r        <= 1'b0;
            blocks_done_r <= '0;
        end else begin
            unique case (state_r)
                eFill: begin
                    if (word_xfer) begin
                        content_r[group_size_p-1-int'(fill_idx_r)*word_width_p -: word_width_p] <= word_i;
                        if (fill_idx_r == '0) begin
                            key_r  <= key_i;
                            mode_r <= mode_i;
                        end
                        if (fill_idx_r == last_idx_lp) begin
                            fill_idx_r <= '0;
                            state_r    <= eIssue;
                        end else begin
                            fill_idx_r <= fill_idx_r + idx_w_lp'(1);
                        end
                    end
                end
                eIssue: begin
                    if (req_xfer) state_r <= eWait;
                end
                eWait: begin
                    if (yumi_o) begin
                        result_r <= crypt_i;
                        state_r  <= eDrain;
                    end
                end
                eDrain: begin
                    if (out_xfer) begin
                        if (drain_idx_r == last_idx_lp) begin
                            drain_idx_r   <= '0;
                            blocks_done_r <= blocks_done_r + 16'd1;
                            state_r       <= eFill;
                        end else begin
                            drain_idx_r <= drain_idx_r + idx_w_lp'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm4_word_driver.sv
// Self-checking bench for sm4_word_driver: directed cycle table, hand-written
// corner sequences and a randomized run against a block-level model.
module tb_sm4_word_driver;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic [31:0]  word_i;
    logic         word_v_i;
    logic         word_ready_o;
    logic [127:0] key_i;
    logic         mode_i;
    logic [127:0] content_o;
    logic [127:0] key_o;
    logic         encode_or_decode_o;
    logic         v_o;
    logic         ready_i;
    logic [127:0] crypt_i;
    logic         crypt_v_i;
    logic         yumi_o;
    logic [31:0]  out_word_o;
    logic         out_v_o;
    logic         out_ready_i;
    logic [15:0]  blocks_done_o;

    always #5 clk_i = ~clk_i;

    sm4_word_driver #(.word_width_p(32)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .word_i(word_i), .word_v_i(word_v_i), .word_ready_o(word_ready_o),
        .key_i(key_i), .mode_i(mode_i),
        .content_o(content_o), .key_o(key_o),
        .encode_or_decode_o(encode_or_decode_o),
        .v_o(v_o), .ready_i(ready_i),
        .crypt_i(crypt_i), .crypt_v_i(crypt_v_i), .yumi_o(yumi_o),
        .out_word_o(out_word_o), .out_v_o(out_v_o),
        .out_ready_i(out_ready_i), .blocks_done_o(blocks_done_o)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Stand-in engine transform used by the random phase.
    function automatic logic [127:0] eng(input logic [127:0] c,
                                         input logic [127:0] k,
                                         input logic m);
        return {c[63:0], c[127:64]} ^ k ^ {128{m}};
    endfunction

    typedef struct {
        logic        rst, wv;
        logic [31:0] w;
        logic        kalt, rdy, cv, ordy;
        logic        e_wr, e_v, e_y, e_ov;
        logic [31:0] e_ow;
        logic [15:0] e_bd;
    } vec_t;

    function automatic vec_t mk(input logic rst, wv, input logic [31:0] w,
                                input logic kalt, rdy, cv, ordy,
                                input logic e_wr, e_v, e_y, e_ov,
                                input logic [31:0] e_ow,
                                input logic [15:0] e_bd);
        vec_t t;
        t.rst = rst; t.wv = wv; t.w = w; t.kalt = kalt;
        t.rdy = rdy; t.cv = cv; t.ordy = ordy;
        t.e_wr = e_wr; t.e_v = e_v; t.e_y = e_y; t.e_ov = e_ov;
        t.e_ow = e_ow; t.e_bd = e_bd;
        return t;
    endfunction

    localparam logic [127:0] K   = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] BLK = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] R   = 128'h681edf34d206965e86b3e94f536e4246;

    vec_t tbl[22];

    // Random-phase model state
    logic [127:0] fill_c, fill_k;
    logic         fill_m;
    int           fill_n = 0;
    logic [127:0] rq_c[$];
    logic [127:0] rq_k[$];
    logic         rq_m[$];
    logic [31:0]  exp_out[$];
    logic         pending = 1'b0;
    logic [127:0] resp;
    int           n_req = 0;

    task automatic observe();
        logic [31:0] ew;
        chk("yumi_rule", yumi_o, pending & crypt_v_i);
        if (word_v_i && word_ready_o) begin
            if (fill_n == 0) begin
                fill_k = key_i;
                fill_m = mode_i;
            end
            fill_c[127-32*fill_n -: 32] = word_i;
            fill_n++;
            if (fill_n == 4) begin
                rq_c.push_back(fill_c);
                rq_k.push_back(fill_k);
                rq_m.push_back(fill_m);
                fill_n = 0;
            end
        end
        if (v_o && ready_i) begin
            if (rq_c.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL req_unexpected: got v_o=1 required no request");
            end else begin
                logic [127:0] c, k;
                logic m;
                c = rq_c.pop_front();
                k = rq_k.pop_front();
                m = rq_m.pop_front();
                chk("req_content", content_o, c);
                chk("req_key", key_o, k);
                chk("req_mode", encode_or_decode_o, m);
                resp = eng(c, k, m);
                pending = 1'b1;
                n_req++;
            end
        end
        if (yumi_o && pending) begin
            for (int j = 0; j < 4; j++) exp_out.push_back(resp[127-32*j -: 32]);
            pending = 1'b0;
        end
        if (out_v_o && out_ready_i) begin
            if (exp_out.size() == 0) begin
                n_chk++; n_err++;
                $display("FAIL out_unexpected: got word %h required none", out_word_o);
            end else begin
                ew = exp_out.pop_front();
                chk("out_word", out_word_o, ew);
            end
        end
    endtask

    logic [31:0] wa[4];
    logic [31:0] wb[4];
    logic [31:0] wf[4];
    logic [127:0] r2;

    initial begin
        reset_i = 1'b1; word_v_i = 1'b1; word_i = '0; key_i = K; mode_i = 1'b1;
        ready_i = 1'b0; crypt_v_i = 1'b1; crypt_i = R; out_ready_i = 1'b0;

        wa[0] = 32'h01234567; wa[1] = 32'h89abcdef;
        wa[2] = 32'hfedcba98; wa[3] = 32'h76543210;

        //            rst wv w      kalt rdy cv ordy  wr v y ov ow  bd
        tbl[0]  = mk(1, 1, wa[0], 0, 0, 1, 0,  0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, wa[0], 0, 0, 1, 0,  0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, wa[0], 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 1, wa[1], 1, 0, 0, 0,  1, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 1, wa[2], 1, 0, 0, 0,  1, 0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 1, wa[3], 1, 0, 0, 0,  1, 0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0,     1, 0, 1, 0,  0, 1, 0, 0, 0, 0);
        for (int i = 7; i <= 10; i++)
            tbl[i] = mk(0, 0, 0, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0);
        tbl[11] = mk(0, 0, 0,     1, 1, 0, 0,  0, 1, 0, 0, 0, 0);
        tbl[12] = mk(0, 0, 0,     1, 0, 0, 0,  0, 0, 0, 0, 0, 0);
        tbl[13] = mk(0, 0, 0,     1, 0, 1, 0,  0, 0, 1, 0, 0, 0);
        tbl[14] = mk(0, 0, 0,     1, 0, 1, 1,  0, 0, 0, 1, 32'h681edf34, 0);
        tbl[15] = mk(0, 0, 0,     1, 0, 0, 0,  0, 0, 0, 1, 32'hd206965e, 0);
        tbl[16] = mk(0, 0, 0,     1, 0, 0, 0,  0, 0, 0, 1, 32'hd206965e, 0);
        tbl[17] = mk(0, 0, 0,     1, 0, 0, 0,  0, 0, 0, 1, 32'hd206965e, 0);
        tbl[18] = mk(0, 0, 0,     1, 0, 0, 1,  0, 0, 0, 1, 32'hd206965e, 0);
        tbl[19] = mk(0, 0, 0,     1, 0, 0, 1,  0, 0, 0, 1, 32'h86b3e94f, 0);
        tbl[20] = mk(0, 0, 0,     1, 0, 0, 1,  0, 0, 0, 1, 32'h536e4246, 0);
        tbl[21] = mk(0, 0, 0,     1, 0, 0, 0,  1, 0, 0, 0, 0, 1);

        tick();
        for (int i = 0; i < 22; i++) begin
            reset_i = tbl[i].rst; word_v_i = tbl[i].wv; word_i = tbl[i].w;
            key_i = tbl[i].kalt ? ~K : K; mode_i = ~tbl[i].kalt;
            ready_i = tbl[i].rdy; crypt_v_i = tbl[i].cv;
            out_ready_i = tbl[i].ordy;
            #1;
            chk($sformatf("t%0d_word_ready", i), word_ready_o, tbl[i].e_wr);
            chk($sformatf("t%0d_v", i), v_o, tbl[i].e_v);
            chk($sformatf("t%0d_yumi", i), yumi_o, tbl[i].e_y);
            chk($sformatf("t%0d_out_v", i), out_v_o, tbl[i].e_ov);
            chk($sformatf("t%0d_blocks", i), blocks_done_o, tbl[i].e_bd);
            if (tbl[i].e_v) begin
                chk($sformatf("t%0d_content", i), content_o, BLK);
                chk($sformatf("t%0d_key", i), key_o, K);
                chk($sformatf("t%0d_mode", i), encode_or_decode_o, 1'b1);
            end
            if (tbl[i].e_ov)
                chk($sformatf("t%0d_out_word", i), out_word_o, tbl[i].e_ow);
            tick();
        end

        // Second block, reset after two drain words.
        wb[0] = 32'h11111111; wb[1] = 32'h22222222;
        wb[2] = 32'h33333333; wb[3] = 32'h44444444;
        r2 = 128'hdeadbeef_cafef00d_01020304_a5a5a5a5;
        out_ready_i = 1'b0; ready_i = 1'b0; crypt_v_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            word_v_i = 1'b1; word_i = wb[i];
            key_i = (i == 0) ? ~K : K; mode_i = (i != 0);
            #1;
            chk("b2_word_ready", word_ready_o, 1'b1);
            tick();
        end
        word_v_i = 1'b0; ready_i = 1'b1;
        #1;
        chk("b2_v", v_o, 1'b1);
        chk("b2_content", content_o, {wb[0], wb[1], wb[2], wb[3]});
        chk("b2_key", key_o, ~K);
        chk("b2_mode", encode_or_decode_o, 1'b0);
        tick();
        ready_i = 1'b0; crypt_v_i = 1'b1; crypt_i = r2;
        #1;
        chk("b2_yumi", yumi_o, 1'b1);
        tick();
        crypt_v_i = 1'b0; out_ready_i = 1'b1;
        #1;
        chk("b2_out0", out_word_o, r2[127:96]);
        tick();
        #1;
        chk("b2_out1", out_word_o, r2[95:64]);
        tick();
        reset_i = 1'b1;
        #1;
        chk("b2_rst_out_v", out_v_o, 1'b0);
        tick();
        reset_i = 1'b0; out_ready_i = 1'b0;
        #1;
        chk("b2_post_out_v", out_v_o, 1'b0);
        chk("b2_post_blocks", blocks_done_o, 16'd0);
        chk("b2_post_ready", word_ready_o, 1'b1);

        // Fresh block after the mid-drain reset.
        wf[0] = 32'h0badf00d; wf[1] = 32'h12345678;
        wf[2] = 32'h9abcdef0; wf[3] = 32'h55aa55aa;
        for (int i = 0; i < 4; i++) begin
            word_v_i = 1'b1; word_i = wf[i]; key_i = K; mode_i = 1'b1;
            tick();
        end
        word_v_i = 1'b0; ready_i = 1'b1;
        #1;
        chk("b3_v", v_o, 1'b1);
        chk("b3_out_v", out_v_o, 1'b0);
        chk("b3_content", content_o, {wf[0], wf[1], wf[2], wf[3]});
        tick();
        ready_i = 1'b0; crypt_v_i = 1'b1; crypt_i = R;
        tick();
        crypt_v_i = 1'b0; out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        out_ready_i = 1'b0;
        #1;
        chk("b3_blocks", blocks_done_o, 16'd1);
        chk("b3_ready", word_ready_o, 1'b1);

        // Randomized traffic against the block model.
        for (int c = 0; c < 4000; c++) begin
            word_v_i = 1'($urandom_range(0, 1));
            word_i = $urandom;
            key_i = {$urandom, $urandom, $urandom, $urandom};
            mode_i = 1'($urandom_range(0, 1));
            ready_i = ($urandom_range(0, 3) != 0);
            out_ready_i = ($urandom_range(0, 3) != 0);
            crypt_v_i = ($urandom_range(0, 2) != 0);
            crypt_i = pending ? resp : {$urandom, $urandom, $urandom, $urandom};
            #1;
            observe();
            tick();
        end

        begin
            int budget;
            budget = 0;
            word_v_i = 1'b0; ready_i = 1'b1; out_ready_i = 1'b1;
            while ((rq_c.size() != 0 || pending || exp_out.size() != 0)
                   && budget < 200) begin
                crypt_v_i = pending;
                crypt_i = resp;
                #1;
                observe();
                tick();
                budget++;
            end
            crypt_v_i = 1'b0;
            if (budget >= 200) begin
                n_chk++; n_err++;
                $display("FAIL flush_timeout: got %0d words left required 0",
                         exp_out.size());
            end
        end
        #1;
        chk("rand_blocks", blocks_done_o, 16'(1 + n_req));
        chk("rand_out_v_idle", out_v_o, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
